mem_disp_ctrl: RTL
==================

// Module: mem_disp_ctrl
// PURPOSE
//  Downstream of the 8-bit address sequencer. Per address step: read one 16-bit word from a
//  synchronous RAM, hold it, and time-multiplex data word + address as hex digits on an
//  8-digit common-anode 7-segment display. Sits between address sequencer, RAM and board pins.
// PARAMETERS
//  MEM_LAT      1   RAM read latency in cycles, mem_rd -> mem_dout valid; legal 1..4
//  REFRESH_BITS 17  width of refresh counter; one digit slot = 2**REFRESH_BITS cycles
// PORTS
//  clk       in   1   system clock, rising edge
//  reset     in   1   asynchronous, active-high
//  addr      in   8   address from sequencer
//  addr_stb  in   1   1-cycle pulse: addr holds a new value this cycle
//  mem_dout  in   16  RAM read data
//  mem_rd    out  1   1-cycle RAM read strobe
//  mem_addr  out  8   RAM address, stable from mem_rd until next request
//  busy      out  1   read in progress (REQ/WAIT)
//  done      out  1   1-cycle pulse when new word latched
//  anodes    out  8   digit enables, active-low, one-hot-zero
//  seg       out  7   {g,f,e,d,c,b,a}, active-low
//  dp        out  1   decimal point, active-low; held 1 (off)
// BEHAVIOUR
//  Reset (async): mem_rd=0, mem_addr=0, busy=0, done=0, data_reg=0, disp_addr=0,
//   pend=0, refresh_cnt=0, dig_idx=0, anodes=8'hFF, seg=7'h7F, dp=1; FSM=IDLE.
//  FSM IDLE -> REQ -> WAIT -> LATCH -> IDLE.
//   IDLE: on addr_stb (or pend=1): mem_addr<=addr (or pend_addr), pend<=0, go REQ.
//   REQ (1 cyc): mem_rd=1, busy=1; go WAIT, wait_cnt<=MEM_LAT-1.
//   WAIT: busy=1; decrement wait_cnt; at 0 go LATCH.
//   LATCH (1 cyc): data_reg<=mem_dout, disp_addr<=mem_addr, done=1, busy=0; go IDLE.
//  Latency: addr_stb cycle N -> mem_rd cycle N+1 -> done cycle N+2+MEM_LAT.
//  addr_stb while not IDLE: pend<=1, pend_addr<=addr; later strobes overwrite pend_addr
//   (one-deep, newest wins); pending read starts first IDLE cycle after LATCH.
//  addr_stb in same cycle as LATCH: captured as pending, not lost.
//  Reset mid-read: request abandoned, no done, display returns to zeros.
//  Address wrap 8'hFF -> 8'h00 needs no special handling; each strobe is one read.
//  Display: refresh_cnt free-runs, wraps to 0. When all-ones, dig_idx advances:
//   0..5 then wraps to 0 (0..3 without macro).
//   Digit map: 0-3 = data_reg[3:0],[7:4],[11:8],[15:12]; 4-5 = disp_addr[3:0],[7:4].
//   anodes/seg registered from dig_idx: anodes = ~(8'b1 << dig_idx) from first cycle after
//   reset; digits 6,7 always off.
//   Hex decode (active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10
//   A=08 b=03 C=46 d=21 E=06 F=0E.
//  Display never blanks during reads; shows last latched word until LATCH.
// CONFIGURATION
//  MDC_ADDR_DISP_EN defined: 6 digits scanned (data + address), dig_idx 0..5.
//  Not defined: 4 digits (data only), dig_idx 0..3, anodes[7:4] always 1; disp_addr omitted.
// TESTING  (REFRESH_BITS=2, MEM_LAT=1 unless stated)
//  1 Reset mid-scan and mid-WAIT -> all outputs at reset values same cycle; no done afterwards.
//  2 addr=8'h05, addr_stb @N, RAM[05]=16'hBEEF -> mem_rd=1,mem_addr=05 @N+1; done @N+3;
//    digits 0..5 show F,E,E,b,5,0 (seg 0E,06,06,03,12,40).
//  3 MEM_LAT=3: addr_stb @N -> done @N+5, busy high N+1..N+4.
//  4 Strobes addr=10 @N, 11 @N+1, 12 @N+2 -> reads of 10 then 12 only; 11 never on mem_addr.
//  5 addr 8'hFF then 8'h00 strobes, RAM[00]=16'h0000 -> digits show 0000, address 00.
//  6 Build without MDC_ADDR_DISP_EN -> anodes cycle FE,FD,FB,F7,FE; never EF/DF.

Source files
------------

// File: rtl/mem_disp_ctrl.sv
// mem_disp_ctrl: fetches one 16-bit word from a synchronous RAM for each address strobe
// from the sequencer, then scans that word (and optionally its address) as hex digits onto
// an 8-digit common-anode 7-segment display.
//
// Build option: define MDC_ADDR_DISP_EN to also show the address on digits 4-5
// (6 digits scanned). Without it, only the 4 data digits are scanned.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   addr, addr_stb  new address and its 1-cycle qualifier
//   mem_dout        RAM read data, valid MEM_LAT cycles after mem_rd
//   mem_rd          1-cycle RAM read strobe
//   mem_addr        RAM address, held until the next request
//   busy            high while a read is in REQ/WAIT
//   done            1-cycle pulse in the cycle the word is latched
//   anodes          digit enables, active-low
//   seg, dp         segments {g,f,e,d,c,b,a} and decimal point, active-low
module mem_disp_ctrl #(
  parameter int unsigned MEM_LAT      = 1,
  parameter int unsigned REFRESH_BITS = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  addr,
  input  logic        addr_stb,
  input  logic [15:0] mem_dout,
  output logic        mem_rd,
  output logic [7:0]  mem_addr,
  output logic        busy,
  output logic        done,
  output logic [7:0]  anodes,
  output logic [6:0]  seg,
  output logic        dp
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StLatch} state_e;

`ifdef MDC_ADDR_DISP_EN
  localparam logic [2:0] LastDig = 3'd5;
`else
  localparam logic [2:0] LastDig = 3'd3;
`endif
  localparam logic [REFRESH_BITS-1:0] RefOne = 1;
  localparam logic [1:0] WaitInit = 2'(MEM_LAT - 1);

  state_e                  state_q, state_d;
  logic [1:0]              wait_cnt_q, wait_cnt_d;
  logic                    pend_q, pend_d;
  logic [7:0]              pend_addr_q, pend_addr_d;
  logic                    mem_rd_q, mem_rd_d;
  logic [7:0]              mem_addr_q, mem_addr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [15:0]             data_reg_q, data_reg_d;
`ifdef MDC_ADDR_DISP_EN
  logic [7:0]              disp_addr_q, disp_addr_d;
`endif
  logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
  logic [2:0]              dig_idx_q, dig_idx_d;
  logic [7:0]              anodes_q, anodes_d;
  logic [6:0]              seg_q, seg_d;
  logic [3:0]              nib;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // Read sequencer
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    mem_rd_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    data_reg_d  = data_reg_q;
`ifdef MDC_ADDR_DISP_EN
    disp_addr_d = disp_addr_q;
`endif
    // One-deep pending slot, newest strobe wins; covers strobes during LATCH too.
    if (addr_stb && (state_q != StIdle)) begin
      pend_d      = 1'b1;
      pend_addr_d = addr;
    end
    case (state_q)
      StIdle: begin
        if (addr_stb || pend_q) begin
          mem_addr_d = addr_stb ? addr : pend_addr_q;
          pend_d     = 1'b0;
          mem_rd_d   = 1'b1;
          busy_d     = 1'b1;
          state_d    = StReq;
        end
      end
      StReq: begin
        wait_cnt_d = WaitInit;
        state_d    = StWait;
      end
      StWait: begin
        if (wait_cnt_q == 2'd0) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StLatch;
        end else begin
          wait_cnt_d = wait_cnt_q - 2'd1;
        end
      end
      StLatch: begin
        data_reg_d = mem_dout;
`ifdef MDC_ADDR_DISP_EN
        disp_addr_d = mem_addr_q;
`endif
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Digit source for the currently selected slot
  always_comb begin
    nib = 4'h0;
    case (dig_idx_q)
      3'd0: nib = data_reg_q[3:0];
      3'd1: nib = data_reg_q[7:4];
      3'd2: nib = data_reg_q[11:8];
      3'd3: nib = data_reg_q[15:12];
`ifdef MDC_ADDR_DISP_EN
      3'd4: nib = disp_addr_q[3:0];
      3'd5: nib = disp_addr_q[7:4];
`endif
      default: nib = 4'h0;
    endcase
  end

  // Display scan
  always_comb begin
    refresh_d = refresh_q + RefOne;
    dig_idx_d = dig_idx_q;
    if (&refresh_q) begin
      dig_idx_d = (dig_idx_q == LastDig) ? 3'd0 : dig_idx_q + 3'd1;
    end
    anodes_d = ~(8'b1 << dig_idx_q);
    seg_d    = hex7(nib);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      wait_cnt_q  <= 2'd0;
      pend_q      <= 1'b0;
      pend_addr_q <= 8'h00;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      data_reg_q  <= 16'h0000;
`ifdef MDC_ADDR_DISP_EN
      disp_addr_q <= 8'h00;
`endif
      refresh_q   <= '0;
      dig_idx_q   <= 3'd0;
      anodes_q    <= 8'hFF;
      seg_q       <= 7'h7F;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      data_reg_q  <= data_reg_d;
`ifdef MDC_ADDR_DISP_EN
      disp_addr_q <= disp_addr_d;
`endif
      refresh_q   <= refresh_d;
      dig_idx_q   <= dig_idx_d;
      anodes_q    <= anodes_d;
      seg_q       <= seg_d;
    end
  end

  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign anodes   = anodes_q;
  assign seg      = seg_q;
  assign dp       = 1'b1;

endmodule
